// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one word request at a time, programmable wait
// states, then a single-cycle response carrying load data or an error flag.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_busy;

    // Contents start at zero and survive reset.
    logic [31:0] r_mem [DEPTH_WORDS] = '{default: 32'h0};

    logic             w_accept;
    logic             w_enter_resp;
    logic             w_acc_write;
    logic [31:0]      w_acc_addr;
    logic [31:0]      w_acc_wdata;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd;
    logic             w_mem_we;

    assign w_accept     = (r_state == S_IDLE) && req_valid;
    assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                          ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // With zero wait states the access happens on the acceptance edge, before the
    // request has been latched, so the live inputs are used instead.
    assign w_acc_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_err    = (w_acc_addr[1:0] != 2'b00) ||
                      (w_acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_idx    = w_acc_addr[IDX_W+1:2];
    assign w_rd     = r_mem[w_idx];
    assign w_mem_we = !reset && w_enter_resp && w_acc_write && !w_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= WAIT_INIT;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= 32'h0;
                    r_resp_err   <= 1'b0;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase

            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_acc_write || w_err) ? 32'h0 : w_rd;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 2, 0 and 5 wait states
// driven from a vector table plus hand-written multi-cycle sequences.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst;
    logic [2:0]       req_valid;
    logic [2:0]       req_write;
    logic [2:0][31:0] req_addr;
    logic [2:0][31:0] req_wdata;
    logic [2:0]       req_ready;
    logic [2:0]       resp_valid;
    logic [2:0][31:0] resp_rdata;
    logic [2:0]       resp_err;
    logic [2:0]       busy;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .busy(busy[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .busy(busy[1])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(5)) u_w5 (
        .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]),
        .busy(busy[2])
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with instance i idle. Returns the response and
    // the number of edges from acceptance to the edge that samples resp_valid.
    task automatic do_req(input int i, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic er, output int edges, output logic bz);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        edges = 1;
        bz    = busy[i];
        while (!resp_valid[i] && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        rd = resp_rdata[i];
        er = resp_err[i];
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        bz;
        int          edges;
        int          acc;
        int          pulses;
        int          last_pulse;
        int          low;
        int          seen;
        logic        pr;

        vecs[0] = '{"st_40",       1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1] = '{"ld_40",       1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{"ld_42_misal", 1'b0, 32'h0000_0042, 32'h0,         32'h0,         1'b1};
        vecs[3] = '{"st_400_oor",  1'b1, 32'h0000_0400, 32'h1111_1111, 32'h0,         1'b1};
        vecs[4] = '{"ld_000",      1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
        vecs[5] = '{"st_3fc_last", 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[6] = '{"ld_3fc_last", 1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[7] = '{"ld_401_bad",  1'b0, 32'h0000_0401, 32'h0,         32'h0,         1'b1};
        vecs[8] = '{"st_41_misal", 1'b1, 32'h0000_0041, 32'h1234_5678, 32'h0,         1'b1};
        vecs[9] = '{"ld_40_again", 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};

        rst       = 3'b111;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 3'b000;

        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d_ready", i), 32'(req_ready[i]),  32'd1);
            check($sformatf("rst%0d_valid", i), 32'(resp_valid[i]), 32'd0);
            check($sformatf("rst%0d_rdata", i), resp_rdata[i],      32'd0);
            check($sformatf("rst%0d_err", i),   32'(resp_err[i]),   32'd0);
            check($sformatf("rst%0d_busy", i),  32'(busy[i]),       32'd0);
        end

        // Two wait states: table of stores/loads/errors.
        for (int v = 0; v < 10; v++) begin
            do_req(0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd, er, edges, bz);
            check({vecs[v].name, "_rdata"}, rd, vecs[v].exp_rdata);
            check({vecs[v].name, "_err"}, 32'(er), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_latency"}, 32'(edges), 32'd3);
            check({vecs[v].name, "_busy"}, 32'(bz), 32'd1);
        end

        // Back-to-back stores with req_valid held high.
        acc        = 0;
        pulses     = 0;
        last_pulse = -1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0;
        req_wdata[0] = 32'd1;
        for (int c = 1; c <= 16; c++) begin
            pr = req_ready[0] && req_valid[0];
            @(posedge clk); #1;
            if (pr) begin
                acc++;
                if (acc == 3) begin
                    req_valid[0] = 1'b0;
                end else begin
                    req_addr[0]  = 32'(acc * 4);
                    req_wdata[0] = 32'(acc + 1);
                end
            end
            if (resp_valid[0]) begin
                pulses++;
                if (last_pulse >= 0) check("b2b_spacing", 32'(c - last_pulse), 32'd4);
                last_pulse = c;
            end
        end
        req_write[0] = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd3);
        check("b2b_pulses", 32'(pulses), 32'd3);
        for (int k = 0; k < 3; k++) begin
            do_req(0, 1'b0, 32'(k * 4), 32'h0, rd, er, edges, bz);
            check($sformatf("b2b_ld%0d", k), rd, 32'(k + 1));
        end

        // Zero wait states: response in the cycle right after acceptance.
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 32'h10;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("w0_resp_valid", 32'(resp_valid[1]), 32'd1);
        check("w0_rdata", resp_rdata[1], 32'h0);
        check("w0_busy", 32'(busy[1]), 32'd1);
        low = 0;
        while (!req_ready[1] && low < 10) begin
            low++;
            @(posedge clk); #1;
        end
        check("w0_ready_low_cycles", 32'(low), 32'd1);
        check("w0_valid_cleared", 32'(resp_valid[1]), 32'd0);

        // Reset two cycles into a five-wait-state store.
        seen = 0;
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'h55;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        req_write[2] = 1'b0;
        if (resp_valid[2]) seen++;
        @(posedge clk); #1;
        if (resp_valid[2]) seen++;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        check("rstw_ready", 32'(req_ready[2]), 32'd1);
        check("rstw_busy", 32'(busy[2]), 32'd0);
        for (int c = 0; c < 10; c++) begin
            if (resp_valid[2]) seen++;
            @(posedge clk); #1;
        end
        check("rstw_no_resp", 32'(seen), 32'd0);
        do_req(2, 1'b0, 32'h20, 32'h0, rd, er, edges, bz);
        check("rstw_ld20", rd, 32'h0);
        check("rstw_ld_latency", 32'(edges), 32'd6);

        // Request coincident with reset is dropped.
        seen = 0;
        rst[2]       = 1'b1;
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h24;
        req_wdata[2] = 32'h77;
        @(posedge clk); #1;
        rst[2]       = 1'b0;
        req_valid[2] = 1'b0;
        req_write[2] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (resp_valid[2] || busy[2]) seen++;
            @(posedge clk); #1;
        end
        check("rstreq_no_activity", 32'(seen), 32'd0);
        do_req(2, 1'b0, 32'h24, 32'h0, rd, er, edges, bz);
        check("rstreq_ld24", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
